// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges integer, floating-point and memory results onto one
// register-file write port, with per-source holding registers and a branch rollback port.
module writeback_arbiter #(
    parameter int THREADS_PER_CORE = 4,
    parameter int VECTOR_LANES     = 16,
    localparam int TW = (THREADS_PER_CORE > 1) ? $clog2(THREADS_PER_CORE) : 1,
    localparam int VW = 32 * VECTOR_LANES
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    dx_valid,
    input  logic [TW-1:0]           dx_thread,
    input  logic                    dx_has_dest,
    input  logic                    dx_is_vector,
    input  logic [4:0]              dx_reg,
    input  logic [VECTOR_LANES-1:0] dx_mask,
    input  logic [VW-1:0]           dx_value,
    output logic                    dx_ready,

    input  logic                    fx_valid,
    input  logic [TW-1:0]           fx_thread,
    input  logic                    fx_has_dest,
    input  logic                    fx_is_vector,
    input  logic [4:0]              fx_reg,
    input  logic [VECTOR_LANES-1:0] fx_mask,
    input  logic [VW-1:0]           fx_value,
    output logic                    fx_ready,

    input  logic                    ix_valid,
    input  logic [TW-1:0]           ix_thread,
    input  logic                    ix_has_dest,
    input  logic                    ix_is_vector,
    input  logic [4:0]              ix_reg,
    input  logic [VECTOR_LANES-1:0] ix_mask,
    input  logic [VW-1:0]           ix_value,
    output logic                    ix_ready,
    input  logic                    ix_branch_taken,
    input  logic [31:0]             ix_branch_target,

    output logic                    wb_writeback_en,
    output logic [TW-1:0]           wb_writeback_thread_idx,
    output logic                    wb_writeback_is_vector,
    output logic [4:0]              wb_writeback_reg,
    output logic [VECTOR_LANES-1:0] wb_writeback_mask,
    output logic [VW-1:0]           wb_writeback_value,

    output logic                    wb_rollback_en,
    output logic [TW-1:0]           wb_rollback_thread_idx,
    output logic [31:0]             wb_rollback_pc
);

    localparam int NUM_SRC = 3;

    // Index order doubles as the fixed priority and the round-robin order.
    typedef enum logic [1:0] {
        SRC_DX = 2'd0,
        SRC_FX = 2'd1,
        SRC_IX = 2'd2
    } src_e;

    typedef struct packed {
        logic [TW-1:0]           thread;
        logic                    is_vector;
        logic [4:0]              dest_reg;
        logic [VECTOR_LANES-1:0] mask;
        logic [VW-1:0]           value;
    } entry_t;

    function automatic src_e next_src(input src_e s);
        case (s)
            SRC_DX:  return SRC_FX;
            SRC_FX:  return SRC_IX;
            default: return SRC_DX;
        endcase
    endfunction

    entry_t               arr_entry  [NUM_SRC];
    entry_t               held_entry [NUM_SRC];
    entry_t               win_entry;
    logic [NUM_SRC-1:0]   held;
    logic [NUM_SRC-1:0]   held_next;
    logic [NUM_SRC-1:0]   arr_live;
    logic [NUM_SRC-1:0]   load;
    logic [2:0]           cand;
    src_e                 rr_ptr;
    src_e                 win_src;
    logic                 win_valid;
    logic                 win_held;

    assign {ix_ready, fx_ready, dx_ready} = ~held;

    assign arr_entry[SRC_DX] = '{dx_thread, dx_is_vector, dx_reg, dx_mask, dx_value};
    assign arr_entry[SRC_FX] = '{fx_thread, fx_is_vector, fx_reg, fx_mask, fx_value};
    assign arr_entry[SRC_IX] = '{ix_thread, ix_is_vector, ix_reg, ix_mask, ix_value};

    // Only accepted results that write a register compete for the port.
    assign arr_live = {ix_valid & ix_has_dest, fx_valid & fx_has_dest, dx_valid & dx_has_dest} & ~held;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        win_valid = 1'b0;
        win_held  = 1'b0;
        win_src   = SRC_DX;
        cand      = 3'd0;
        if (|held) begin
            win_held = 1'b1;
            for (int k = 0; k < NUM_SRC; k++) begin
                cand = {1'b0, rr_ptr} + 3'(k);
                if (cand >= 3'(NUM_SRC))
                    cand = cand - 3'(NUM_SRC);
                if (!win_valid && held[cand[1:0]]) begin
                    win_valid = 1'b1;
                    win_src   = src_e'(cand[1:0]);
                end
            end
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (!win_valid && arr_live[s]) begin
                    win_valid = 1'b1;
                    win_src   = src_e'(s);
                end
            end
        end

        load = arr_live;
        if (win_valid && !win_held)
            load[win_src] = 1'b0;

        held_next = held | load;
        if (win_held)
            held_next[win_src] = 1'b0;

        win_entry = win_held ? held_entry[win_src] : arr_entry[win_src];
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held            <= '0;
            rr_ptr          <= SRC_DX;
            wb_writeback_en <= 1'b0;
            wb_rollback_en  <= 1'b0;
        end else begin
            held            <= held_next;
            if (win_held)
                rr_ptr <= next_src(win_src);
            wb_writeback_en <= win_valid;
            wb_rollback_en  <= ix_valid && ix_ready && ix_branch_taken;
        end
    end

    // NOTE: payload registers are qualified by held/enable bits, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (load[s])
                held_entry[s] <= arr_entry[s];
        end

        wb_writeback_thread_idx <= win_entry.thread;
        wb_writeback_is_vector  <= win_entry.is_vector;
        wb_writeback_reg        <= win_entry.dest_reg;
        if (win_entry.is_vector) begin
            wb_writeback_mask  <= win_entry.mask;
            wb_writeback_value <= win_entry.value;
        end else begin
            wb_writeback_mask  <= '1;
            wb_writeback_value <= VW'(win_entry.value[31:0]);
        end

        wb_rollback_thread_idx <= ix_thread;
        wb_rollback_pc         <= ix_branch_target;
    end

endmodule
